// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-lite master and its neighbours.
//   state_t        : master FSM state encoding (also exported on the debug port)
//   OKAY..DECERR   : AXI BRESP/RRESP codes
//   DEF_ADDR_W/_W  : default address (word index) and data widths
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/axi_lite_master.sv
// Command-driven AXI4-lite master: accepts one single-beat read or write
// command at a time, runs the AW/W/B or AR/R handshakes and returns the
// read data / response code on a response port. A per-transaction timeout
// aborts a transaction whose slave never answers.
//
// Ports:
//   axi_clk, rstn                 clock, synchronous active-low reset
//   cmd_*                         command port (cmd_ready = master idle)
//   rsp_*                         response port (rdata, resp, timeout flag)
//   write_addr*/write_data*/write_resp*   AXI AW/W/B channels
//   read_addr*/read_data*/read_resp       AXI AR/R channels
//   state_dbg                     current FSM state, for checkers
//
// Handshake semantics (every channel, both directions): a transfer happens on
// the rising edge where valid & ready are both 1. Once valid is raised, it and
// its payload stay stable until that transfer; ready may toggle freely and
// never influences valid combinationally.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              axi_clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_addr_valid,
    input  logic              write_addr_ready,
    output logic [DATA_W-1:0] write_data,
    output logic              write_data_valid,
    input  logic              write_data_ready,
    input  logic [1:0]        write_resp,
    input  logic              write_resp_valid,
    output logic              write_resp_ready,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_addr_valid,
    input  logic              read_addr_ready,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              read_data_ready,
    input  logic [1:0]        read_resp,
    output logic [2:0]        state_dbg
);

    // A zero TIMEOUT_CYCLES disables the timeout; keep a 1-bit counter then.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
    logic aw_all, w_all, busy, expire, abort;

    assign cmd_fire = (state_q == IDLE) && cmd_valid;
    assign aw_fire  = awvalid_q && write_addr_ready;
    assign w_fire   = wvalid_q && write_data_ready;
    assign b_fire   = bready_q && write_resp_valid;
    assign ar_fire  = arvalid_q && read_addr_ready;
    assign r_fire   = rready_q && read_data_valid;
    assign rsp_fire = rsp_valid_q && rsp_ready;

    // A channel counts as done if it completed earlier or completes this edge.
    assign aw_all = aw_done_q || aw_fire;
    assign w_all  = w_done_q || w_fire;

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_DATA);

    // The counter keeps running across the request and response phases, so
    // the budget covers the whole transaction. Expiry is evaluated one count
    // early so the abort lands on the TIMEOUT_CYCLES-th busy edge.
    assign expire = (TIMEOUT_CYCLES != 0) && busy && (cnt_q >= CNT_LAST);

    // State register
    always_ff @(posedge axi_clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a state-advancing handshake takes priority over expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_all && w_all) state_d = WR_RESP;
                     else if (expire)     state_d = DONE;
            WR_RESP: if (b_fire || expire) state_d = DONE;
            RD_REQ:  if (ar_fire)     state_d = RD_DATA;
                     else if (expire) state_d = DONE;
            RD_DATA: if (r_fire || expire) state_d = DONE;
            DONE:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;
        cnt_d         = (busy && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    awvalid_d = cmd_write;
                    wvalid_d  = cmd_write;
                    arvalid_d = !cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                end
            end
            WR_REQ: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_all && w_all) begin
                    bready_d = 1'b1;
                end else if (expire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    abort     = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_fire) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = write_resp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (expire) begin
                    bready_d = 1'b0;
                    abort    = 1'b1;
                end
            end
            RD_REQ: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expire) begin
                    arvalid_d = 1'b0;
                    abort     = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_fire) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = read_data;
                    rsp_resp_d    = read_resp;
                    rsp_timeout_d = 1'b0;
                end else if (expire) begin
                    rready_d = 1'b0;
                    abort    = 1'b1;
                end
            end
            DONE: begin
                if (rsp_fire) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (abort) begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = OKAY;
            rsp_rdata_d   = '0;
        end
    end

    // Output / payload registers
    always_ff @(posedge axi_clk) begin
        if (!rstn) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready        = (state_q == IDLE);
    assign write_addr       = addr_q;
    assign write_addr_valid = awvalid_q;
    assign write_data       = wdata_q;
    assign write_data_valid = wvalid_q;
    assign write_resp_ready = bready_q;
    assign read_addr        = addr_q;
    assign read_addr_valid  = arvalid_q;
    assign read_data_ready  = rready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_resp         = rsp_resp_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a scripted slave with per-channel stall counts,
// a memory reference model and an expected-response queue.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic axi_clk = 1'b0;
    logic rstn;
    always #5 axi_clk = ~axi_clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] write_addr, read_addr;
    logic          write_addr_valid, write_addr_ready;
    logic [DW-1:0] write_data, read_data;
    logic          write_data_valid, write_data_ready;
    logic [1:0]    write_resp, read_resp;
    logic          write_resp_valid, write_resp_ready;
    logic          read_addr_valid, read_addr_ready;
    logic          read_data_valid, read_data_ready;
    logic [2:0]    state_dbg;

    axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(axi_clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .write_addr(write_addr), .write_addr_valid(write_addr_valid),
        .write_addr_ready(write_addr_ready),
        .write_data(write_data), .write_data_valid(write_data_valid),
        .write_data_ready(write_data_ready),
        .write_resp(write_resp), .write_resp_valid(write_resp_valid),
        .write_resp_ready(write_resp_ready),
        .read_addr(read_addr), .read_addr_valid(read_addr_valid),
        .read_addr_ready(read_addr_ready),
        .read_data(read_data), .read_data_valid(read_data_valid),
        .read_data_ready(read_data_ready), .read_resp(read_resp),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW+2:0] exp_q[$];            // {rdata, resp, timeout}
    logic [DW-1:0] ref_mem[4];          // what the register space should hold
    logic [DW-1:0] slv_mem[4];          // what the slave actually received
    int b_count = 0;

    always @(posedge axi_clk)
        if (write_resp_valid && write_resp_ready) b_count <= b_count + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge axi_clk); n++; end
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        @(negedge axi_clk);
        cmd_valid = 1'b0;
        check("req_latency", 64'({write_addr_valid, write_data_valid, read_addr_valid}),
              64'(wr ? 3'b110 : 3'b001));
        check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    endtask

    task automatic slv_aw(input int dly, input logic [AW-1:0] ea, output logic [AW-1:0] got);
        int n = 0;
        while (!write_addr_valid && n < 50) begin @(negedge axi_clk); n++; end
        for (int i = 0; i <= dly; i++) begin
            if (i > 0) @(negedge axi_clk);
            check("aw_hold", 64'({write_addr_valid, write_addr}), 64'({1'b1, ea}));
        end
        got = write_addr;
        write_addr_ready = 1'b1;
        @(negedge axi_clk);
        write_addr_ready = 1'b0;
        check("aw_drop", 64'(write_addr_valid), 64'(0));
    endtask

    task automatic slv_w(input int dly, input logic [DW-1:0] ed, output logic [DW-1:0] got);
        int n = 0;
        while (!write_data_valid && n < 50) begin @(negedge axi_clk); n++; end
        for (int i = 0; i <= dly; i++) begin
            if (i > 0) @(negedge axi_clk);
            check("w_hold", 64'({write_data_valid, write_data}), 64'({1'b1, ed}));
        end
        got = write_data;
        write_data_ready = 1'b1;
        @(negedge axi_clk);
        write_data_ready = 1'b0;
        check("w_drop", 64'(write_data_valid), 64'(0));
    endtask

    task automatic slv_b(input int dly, input logic [1:0] resp);
        int n = 0;
        while (!write_resp_ready && n < 50) begin @(negedge axi_clk); n++; end
        check("b_ready", 64'(write_resp_ready), 64'(1));
        for (int i = 0; i < dly; i++) begin
            @(negedge axi_clk);
            check("b_ready_hold", 64'(write_resp_ready), 64'(1));
        end
        write_resp_valid = 1'b1; write_resp = resp;
        @(negedge axi_clk);
        write_resp_valid = 1'b0;
        check("b_ready_drop", 64'(write_resp_ready), 64'(0));
    endtask

    task automatic slv_ar(input int dly, input logic [AW-1:0] ea, output logic [AW-1:0] got);
        int n = 0;
        while (!read_addr_valid && n < 50) begin @(negedge axi_clk); n++; end
        for (int i = 0; i <= dly; i++) begin
            if (i > 0) @(negedge axi_clk);
            check("ar_hold", 64'({read_addr_valid, read_addr}), 64'({1'b1, ea}));
        end
        got = read_addr;
        read_addr_ready = 1'b1;
        @(negedge axi_clk);
        read_addr_ready = 1'b0;
        check("ar_drop", 64'(read_addr_valid), 64'(0));
    endtask

    task automatic slv_r(input int dly, input logic [DW-1:0] d, input logic [1:0] resp);
        int n = 0;
        while (!read_data_ready && n < 50) begin @(negedge axi_clk); n++; end
        check("r_ready", 64'(read_data_ready), 64'(1));
        for (int i = 0; i < dly; i++) begin
            @(negedge axi_clk);
            check("r_ready_hold", 64'(read_data_ready), 64'(1));
        end
        read_data_valid = 1'b1; read_data = d; read_resp = resp;
        @(negedge axi_clk);
        read_data_valid = 1'b0;
        check("r_ready_drop", 64'(read_data_ready), 64'(0));
    endtask

    task automatic consume(input int hold);
        logic [DW+2:0] e;
        int n = 0;
        while (!rsp_valid && n < 50) begin @(negedge axi_clk); n++; end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("exp_q_size", 64'(exp_q.size()), 64'(1));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int i = 0; i < hold; i++) begin
            check("rsp_stall", 64'({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout}),
                  64'({1'b1, 1'b0, e}));
            @(negedge axi_clk);
        end
        check("rsp_payload", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'(e));
        rsp_ready = 1'b1;
        @(negedge axi_clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    // Write: da = AW stall, db = W stall, dc = B stall. Read: da = AR stall, dc = R stall.
    task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int da, input int db, input int dc,
                       input logic [1:0] resp, input int hold);
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        int b0;
        if (wr) begin
            exp_q.push_back({{DW{1'b0}}, resp, 1'b0});
            ref_mem[a] = d;
        end else begin
            exp_q.push_back({ref_mem[a], resp, 1'b0});
        end
        b0 = b_count;
        issue_cmd(wr, a, d);
        if (wr) begin
            fork
                slv_aw(da, a, ga);
                slv_w(db, d, gd);
            join
            slv_mem[ga] = gd;
            slv_b(dc, resp);
        end else begin
            slv_ar(da, a, ga);
            slv_r(dc, slv_mem[ga], resp);
        end
        consume(hold);
        if (wr) check("b_count", 64'(b_count - b0), 64'(1));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        rstn = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 0;
        write_addr_ready = 0; write_data_ready = 0;
        write_resp = '0; write_resp_valid = 0;
        read_addr_ready = 0; read_data = '0; read_data_valid = 0; read_resp = '0;
        for (int i = 0; i < 4; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end

        repeat (3) @(negedge axi_clk);
        check("reset_outputs", 64'({cmd_ready, write_addr_valid, write_data_valid, write_resp_ready,
                                    read_addr_valid, read_data_ready, rsp_valid, rsp_timeout}),
              64'(8'b1000_0000));
        check("reset_payload", 64'({rsp_rdata, rsp_resp}), 64'(0));
        check("reset_state", 64'(state_dbg), 64'(IDLE));
        rstn = 1'b1;
        @(negedge axi_clk);

        // Basic write, slave ready at once
        txn(1'b1, 2'd2, 32'hDEADBEEF, 0, 0, 0, OKAY, 0);
        // W completes three cycles before AW
        txn(1'b1, 2'd1, 32'h12345678, 3, 0, 0, OKAY, 0);
        // Read with two R wait cycles and SLVERR
        txn(1'b0, 2'd1, 32'h0, 0, 0, 2, SLVERR, 0);

        // Slave never raises ARREADY: abort after TO busy cycles
        exp_q.push_back({{DW{1'b0}}, OKAY, 1'b1});
        issue_cmd(1'b0, 2'd3, 32'h0);
        cnt = 0;
        while (read_addr_valid && cnt < 50) begin cnt++; @(negedge axi_clk); end
        check("to_ar_cycles", 64'(cnt), 64'(TO));
        check("to_ready_low", 64'(read_data_ready), 64'(0));
        consume(2);
        // Next command proceeds normally
        txn(1'b0, 2'd2, 32'h0, 1, 0, 1, EXOKAY, 0);

        // Consumer stalls five cycles
        txn(1'b0, 2'd2, 32'h0, 1, 0, 1, OKAY, 5);

        // AR handshake on the expiry edge wins; R follows immediately
        txn(1'b0, 2'd1, 32'h0, TO - 1, 0, 0, DECERR, 0);

        // Reset while in WR_REQ
        issue_cmd(1'b1, 2'd0, 32'hCAFE0001);
        @(negedge axi_clk);
        rstn = 1'b0;
        @(negedge axi_clk);
        check("rst_mid_valids", 64'({write_addr_valid, write_data_valid, write_resp_ready,
                                     read_addr_valid, read_data_ready, rsp_valid}), 64'(0));
        rstn = 1'b1;
        @(negedge axi_clk);
        check("rst_mid_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
        @(negedge axi_clk);
        check("rst_mid_no_rsp", 64'(rsp_valid), 64'(0));

        // Randomized traffic within the timeout budget
        for (int k = 0; k < 24; k++) begin
            txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
Command-driven AXI4-lite master that sits directly upstream of the team's AXI4-lite register slave and drives its AW/W/B and AR/R channels. Local logic (test sequencer, UART bridge, CPU-less controller) issues one single-beat read or write command at a time. The master runs the full channel handshakes and returns read data and response status on a valid/ready response port. A timeout counter guarantees forward progress if the slave never answers.

Parameters:
ADDR_W, 2, AXI address width (word index, 4-byte aligned)
DATA_W, 32, AXI data width
TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; 0 disables the timeout

Ports:
axi_clk  in  1  clock
rstn  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  master idle, command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP captured from the slave (0 on timeout)
rsp_timeout  out  1  transaction aborted by the timeout
write_addr  out  ADDR_W  AWADDR
write_addr_valid  out  1  AWVALID
write_addr_ready  in  1  AWREADY
write_data  out  DATA_W  WDATA
write_data_valid  out  1  WVALID
write_data_ready  in  1  WREADY
write_resp  in  2  BRESP
write_resp_valid  in  1  BVALID
write_resp_ready  out  1  BREADY
read_addr  out  ADDR_W  ARADDR
read_addr_valid  out  1  ARVALID
read_addr_ready  in  1  ARREADY
read_data  in  DATA_W  RDATA
read_data_valid  in  1  RVALID
read_data_ready  out  1  RREADY
read_resp  in  2  RRESP

Behaviour:
- Reset: rstn is synchronous and active-low; the clock is axi_clk. While rstn=0 at a posedge: state=IDLE, all *_valid=0, write_resp_ready=0, read_data_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, payload regs=0, timeout counter=0.
- Reset mid-transaction: all outstanding valids drop on that edge. No response is produced.
- All AXI outputs and rsp_* are registered. cmd_ready = (state==IDLE), combinational from state.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE, on command accept:
  - Latch addr and wdata.
  - Write: next state WR_REQ. write_addr_valid=1 and write_data_valid=1 from the next cycle (1-cycle latency).
  - Read: next state RD_REQ. read_addr_valid=1 from the next cycle.
- WR_REQ:
  - Track aw_done and w_done independently.
  - Each valid deasserts on the edge where valid&ready is sampled high.
  - AW and W may complete in the same cycle or in either order.
  - The valid and payload of a channel are held stable until its handshake. The master must tolerate ready=0 while valid=1 and ready toggling.
  - When both channels are done, go to WR_RESP with write_resp_ready=1.
- WR_RESP: on write_resp_valid & write_resp_ready, capture write_resp into rsp_resp, set rsp_rdata=0, deassert write_resp_ready, go to DONE.
- RD_REQ: on the AR handshake, drop read_addr_valid, go to RD_DATA with read_data_ready=1.
- RD_DATA: on the R handshake, capture read_data and read_resp, drop read_data_ready, go to DONE.
- DONE:
  - rsp_valid=1 and held with stable payload until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; rsp_valid=0 the next cycle.
  - Best case: a new command is accepted 1 cycle after the response handshake.
- Timeout:
  - Counter width is clog2(TIMEOUT_CYCLES+1). It clears on command accept and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - On reaching TIMEOUT_CYCLES: drop all AXI valids and readies, set rsp_timeout=1, rsp_resp=0, rsp_rdata=0, go to DONE.
  - A handshake completing in the same cycle as expiry wins: no timeout is flagged.
  - The counter does not run in DONE; a stalled consumer is not a slave fault.
- Single outstanding transaction only; AW/W and AR are never active together.

Decomposition:
- Shared package axi_lite_pkg holds:
  - FSM state enum.
  - RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Default ADDR_W/DATA_W.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Reset, then write addr=2 data=0xDEADBEEF, slave ready immediately with BRESP=0. Required: AW/W valid 1 cycle after accept, each drops after its handshake, rsp_valid with rsp_resp=0, rsp_timeout=0.
- Write where WREADY arrives 3 cycles before AWREADY. Required: write_data_valid drops first, write_addr_valid and write_addr stay stable until AWREADY, exactly one B accepted.
- Read addr=1 with the slave returning 0x12345678 after 2 wait cycles, RRESP=2. Required: rsp_rdata=0x12345678, rsp_resp=2.
- TIMEOUT_CYCLES=8, slave never asserts ARREADY. Required: read_addr_valid drops at cycle 8, rsp_timeout=1, rsp_rdata=0; the next command is then accepted normally.
- rsp_ready held low for 5 cycles after completion. Required: rsp_valid and payload stable, cmd_ready=0 throughout, no timeout.
- rstn asserted while in WR_REQ. Required: next edge all valids=0, cmd_ready=1 after release, no rsp_valid.
